seq_multiplier_module: RTL

//  Parametrised sequential shift-add multiplier; successor to the combinational 16x16 KPN multiplier node.

---
 rtl/seq_multiplier_module.sv | 134 +++++++++++++
 1 files changed

// File: rtl/seq_multiplier_module.sv
// Sequential shift-add multiplier: one partial product per clock, optional
// two's-complement operands handled by sign-magnitude conversion around an
// unsigned core. Registered 2*WIDTH result, one-cycle done pulse, LCD show flag.
module seq_multiplier_module #(
    parameter int unsigned WIDTH     = 16,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   entry_1,
    input  logic [WIDTH-1:0]   entry_2,
    input  logic               start,
    input  logic               signed_mode,
    input  logic               show_mult,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               show_result
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CntW-1:0]    counter_q, counter_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               done_q, done_d;
    logic               valid_q, valid_d;
    logic               show_q, show_d;

    logic               signed_op;
    logic               sign_1, sign_2;
    logic [WIDTH-1:0]   mag_1, mag_2;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] product;

    // Operand magnitudes and the current partial-product step.
    always_comb begin
        signed_op = SIGNED_EN && signed_mode;
        sign_1    = signed_op && entry_1[WIDTH-1];
        sign_2    = signed_op && entry_2[WIDTH-1];
        // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
        mag_1     = sign_1 ? (~entry_1 + WIDTH'(1)) : entry_1;
        mag_2     = sign_2 ? (~entry_2 + WIDTH'(1)) : entry_2;
        addend    = mplier_q[0] ? mcand_q : '0;
        sum       = {1'b0, acc_q} + {1'b0, addend};
        // Full product as it stands after this step's right shift.
        product   = {sum, mplier_q[WIDTH-1:1]};
    end

    // Next-state logic: accept in IDLE/DONE, iterate WIDTH times in CALC.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        counter_d = counter_q;
        neg_d     = neg_q;
        result_d  = result_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        show_d    = show_mult & valid_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    mcand_d   = mag_1;
                    mplier_d  = mag_2;
                    neg_d     = sign_1 ^ sign_2;
                    acc_d     = '0;
                    counter_d = '0;
                    valid_d   = 1'b0;
                    show_d    = 1'b0;
                    state_d   = StCalc;
                end
            end
            StCalc: begin
                acc_d     = sum[WIDTH:1];
                mplier_d  = {sum[0], mplier_q[WIDTH-1:1]};
                counter_d = counter_q + CntW'(1);
                if (counter_q == CntW'(WIDTH - 1)) begin
                    result_d = neg_q ? (~product + (2 * WIDTH)'(1)) : product;
                    done_d   = 1'b1;
                    valid_d  = 1'b1;
                    state_d  = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            counter_q <= '0;
            neg_q     <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            show_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            counter_q <= counter_d;
            neg_q     <= neg_d;
            result_q  <= result_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            show_q    <= show_d;
        end
    end

    assign busy        = (state_q == StCalc);
    assign done        = done_q;
    assign result      = result_q;
    assign show_result = show_q;

endmodule
